// File: rtl/decoder1_2.sv
// 1-to-2 decoder with an enable, a registered copy of the decoded value and
// one saturating hit counter per output bit.
module decoder1_2 #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in,
    input  logic             enable,
    output logic [1:0]       out,
    output logic [1:0]       out_q,
    output logic [CNT_W-1:0] hit0_cnt,
    output logic [CNT_W-1:0] hit1_cnt
);

    logic [1:0][CNT_W-1:0] cnt;

    // Kept free of clk/reset so that instances can be chained enable-to-out.
    assign out = {enable & in, enable & ~in};

    always_ff @(posedge clk) begin
        if (reset) out_q <= 2'b00;
        else       out_q <= out;
    end

    for (genvar i = 0; i < 2; i++) begin : g_hit
        always_ff @(posedge clk) begin
            if (reset)
                cnt[i] <= '0;
            else if (out[i] && (cnt[i] != {CNT_W{1'b1}}))
                cnt[i] <= cnt[i] + CNT_W'(1);
        end
    end

    assign hit0_cnt = cnt[0];
    assign hit1_cnt = cnt[1];

endmodule

// File: tb/tb_decoder1_2.sv
// Randomized scoreboard bench for decoder1_2: a main instance (CNT_W=8),
// a saturation instance (CNT_W=2) and a three-instance 2-to-4 chain.
module tb_decoder1_2;

    typedef struct {
        logic [1:0] out;
        logic [1:0] outq;
        logic [7:0] h0;
        logic [7:0] h1;
        logic [1:0] s0;
        logic [1:0] s1;
        logic [3:0] o4;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset, in, enable;
    logic [1:0] out, out_q, out_s, out_qs;
    logic [7:0] h0, h1;
    logic [1:0] s0, s1;

    logic       c_en;
    logic [1:0] c_sel;
    logic [1:0] a_out, lo_out, hi_out, a_q, lo_q, hi_q;
    logic [7:0] a_h0, a_h1, lo_h0, lo_h1, hi_h0, hi_h1;

    exp_t q[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    // model state after the most recent edge
    int   m_q, m0, m1, ms0, ms1;
    logic p_rst = 1'b1, p_en = 1'b0, p_in = 1'b0;

    always #5 clk = ~clk;

    decoder1_2 #(.CNT_W(8)) u_main (
        .clk(clk), .reset(reset), .in(in), .enable(enable),
        .out(out), .out_q(out_q), .hit0_cnt(h0), .hit1_cnt(h1));

    decoder1_2 #(.CNT_W(2)) u_sat (
        .clk(clk), .reset(reset), .in(in), .enable(enable),
        .out(out_s), .out_q(out_qs), .hit0_cnt(s0), .hit1_cnt(s1));

    decoder1_2 #(.CNT_W(8)) u_a (
        .clk(clk), .reset(reset), .in(c_sel[1]), .enable(c_en),
        .out(a_out), .out_q(a_q), .hit0_cnt(a_h0), .hit1_cnt(a_h1));

    decoder1_2 #(.CNT_W(8)) u_lo (
        .clk(clk), .reset(reset), .in(c_sel[0]), .enable(a_out[0]),
        .out(lo_out), .out_q(lo_q), .hit0_cnt(lo_h0), .hit1_cnt(lo_h1));

    decoder1_2 #(.CNT_W(8)) u_hi (
        .clk(clk), .reset(reset), .in(c_sel[0]), .enable(a_out[1]),
        .out(hi_out), .out_q(hi_q), .hit0_cnt(hi_h0), .hit1_cnt(hi_h1));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One cycle: account for the edge just taken, then apply new inputs and
    // queue what the DUTs should show for the rest of this cycle.
    task automatic step(input logic r, input logic e, input logic i,
                        input logic ce, input logic [1:0] cs);
        int o;
        exp_t x;
        @(posedge clk);
        #1;
        if (p_rst) begin
            m_q = 0; m0 = 0; m1 = 0; ms0 = 0; ms1 = 0;
        end else begin
            o = p_en ? (1 << p_in) : 0;
            m_q = o;
            if (o == 1) begin
                m0  = (m0  < 255) ? m0  + 1 : 255;
                ms0 = (ms0 < 3)   ? ms0 + 1 : 3;
            end
            if (o == 2) begin
                m1  = (m1  < 255) ? m1  + 1 : 255;
                ms1 = (ms1 < 3)   ? ms1 + 1 : 3;
            end
        end
        reset = r; enable = e; in = i; c_en = ce; c_sel = cs;
        p_rst = r; p_en = e; p_in = i;
        x.out  = e ? 2'(1 << i) : 2'b00;
        x.outq = 2'(m_q);
        x.h0   = 8'(m0);
        x.h1   = 8'(m1);
        x.s0   = 2'(ms0);
        x.s1   = 2'(ms1);
        x.o4   = ce ? 4'(1 << cs) : 4'b0000;
        q.push_back(x);
    endtask

    always @(negedge clk) begin
        exp_t x;
        if (q.size() > 0) begin
            x = q.pop_front();
            chk("out",      32'(out),    32'(x.out));
            chk("out_sat",  32'(out_s),  32'(x.out));
            chk("out_q",    32'(out_q),  32'(x.outq));
            chk("out_q_sat",32'(out_qs), 32'(x.outq));
            chk("hit0_cnt", 32'(h0),     32'(x.h0));
            chk("hit1_cnt", 32'(h1),     32'(x.h1));
            chk("hit0_sat", 32'(s0),     32'(x.s0));
            chk("hit1_sat", 32'(s1),     32'(x.s1));
            chk("dec2to4",  32'({hi_out, lo_out}), 32'(x.o4));
        end
    end

    initial begin
        logic [2:0] v;
        reset = 1'b1; enable = 1'b0; in = 1'b0; c_en = 1'b0; c_sel = 2'b00;

        // reset state
        step(1, 0, 0, 0, 2'b00);
        step(1, 1, 1, 0, 2'b00);

        // enable=1, in=1 for three edges
        step(0, 1, 1, 0, 2'b00);
        step(0, 1, 1, 0, 2'b00);
        step(0, 1, 1, 0, 2'b00);
        step(0, 0, 0, 0, 2'b00);

        // saturation: six edges of out[0]
        step(1, 0, 0, 0, 2'b00);
        repeat (6) step(0, 1, 0, 0, 2'b00);
        step(0, 0, 1, 0, 2'b00);

        // reset priority over a simultaneous increment
        step(1, 0, 0, 0, 2'b00);
        step(0, 1, 1, 0, 2'b00);
        step(0, 1, 1, 0, 2'b00);
        step(1, 1, 1, 0, 2'b00);
        step(0, 1, 1, 0, 2'b00);

        // combinational sweep of {enable,in} and of the 2-to-4 chain
        for (int k = 0; k < 4; k++) begin
            v = 3'(k);
            step(0, v[1], v[0], 0, 2'b00);
        end
        for (int k = 0; k < 8; k++) begin
            v = 3'(k);
            step(0, 0, 0, v[2], v[1:0]);
        end

        // random traffic with occasional reset
        for (int k = 0; k < 300; k++)
            step(($urandom_range(0, 15) == 0), 1'($urandom), 1'($urandom),
                 1'($urandom), 2'($urandom));
        step(0, 0, 0, 0, 2'b00);

        for (int k = 0; k < 10 && q.size() > 0; k++) @(posedge clk);
        if (q.size() > 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL drain: %0d entries left, expected 0", q.size());
        end
        @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
